fp_accumulate: RTL
==================

// Module: fp_accumulate
// PURPOSE
//  Sequential IEEE-754 single-precision accumulator, directly downstream of the FP multiplier.
//  Consumes product words (In_Data/valid_in) and sums N_TERMS of them through a multi-cycle
//  align/add/normalize FSM. Emits the sum on Out with a one-cycle valid_out pulse, then clears.
//  Forms the dot-product / MAC path.
// PARAMETERS
//  N_TERMS   4   products summed per result (>=1)
//  CNT_W     8   width of term counter (2**CNT_W > N_TERMS)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   reset, asynchronous, active-high
//  In_Data    in   32  IEEE-754 single operand (multiplier Out)
//  valid_in   in   1   In_Data valid (multiplier valid_out)
//  ready_out  out  1   block can accept a term this cycle
//  clear_in   in   1   synchronous abort: drop partial sum, counter to 0
//  Out        out  32  accumulated result, held until next result
//  valid_out  out  1   one-cycle pulse, Out updated this cycle
//  ovf_out    out  1   exponent overflow seen in this result (FP_ACC_OVF_EN only)
// BEHAVIOUR
//  - Reset: Out=0, valid_out=0, ready_out=1, ovf_out=0, acc=0, count=0, state=IDLE.
//  - Handshake: term accepted when valid_in && ready_out. valid_in while ready_out=0 is dropped.
//    Upstream rate-limits to at most one term per 4 cycles.
//  - FSM: IDLE -(accept)-> ALIGN -> ADD -> NORM -> (count==N_TERMS ? DONE : IDLE);
//    DONE -> IDLE. ready_out=1 only in IDLE. Throughput: 4 cycles per term.
//  - ALIGN: mantissas {1,frac} (24b); an operand with exp==0 is exact zero.
//    The smaller exponent operand is shifted right by the exponent difference (truncate).
//    A difference >=24 gives zero contribution.
//  - ADD: same signs -> add (25b). Different signs -> larger magnitude minus smaller;
//    result takes the sign of the larger. Equal magnitudes -> +0.
//  - NORM: carry bit24 set -> shift right 1, exp+1. Otherwise leading-zero count lz:
//    shift left lz, exp-lz. Zero mantissa, or exp<=lz (underflow), -> +0.
//    No rounding: truncate, matching multiplier. No denormal/NaN/inf input handling.
//  - Exponent kept in 9b internally. 8-bit result written back to acc, count+1.
//  - DONE: Out<=acc, valid_out=1 for this cycle only; acc<=0, count<=0.
//  - clear_in has priority over all states except reset. Next cycle: IDLE, acc=0, count=0,
//    no valid_out. Out is held.
//  - rst mid-operation: immediate return to reset values. In-flight term lost.
// CONFIGURATION
//  FP_ACC_OVF_EN defined: ovf_out port exists.
//    - NORM exp>=255 -> acc saturates to {sign,8'hFF,23'h0}; sticky ovf flag set.
//    - ovf_out=flag in the DONE cycle, then held with Out; cleared on next DONE, clear_in, rst.
//  Undefined: no ovf_out port; exponent truncated to low 8 bits (wrap), fraction kept.
// STRUCTURE
//  fp_acc_pkg:
//    - state typedef (IDLE, ALIGN, ADD, NORM, DONE)
//    - constants EXP_W=8, FRAC_W=23, MANT_W=24, BIAS=127, EXP_MAX=255
//  Sub-module fp_lzc24: combinational 24-bit leading-zero counter (5b out, 24 for all-zero).
//  Top holds FSM, counter, acc/operand registers, align shifter, adder.
// TESTING
//  1 N_TERMS=4, 4x 0x3F800000 (1.0), one every 4 cycles -> single valid_out pulse, Out=0x40800000.
//  2 N_TERMS=2, 0x40400000 (3.0) then 0xC0200000 (-2.5) -> Out=0x3F000000 (0.5).
//  3 N_TERMS=2, 0x3FC00000 then 0xBFC00000 -> Out=0x00000000 (cancellation).
//  4 N_TERMS=2, 0x4B800000 then 0x3F800000 (diff 24) -> Out=0x4B800000.
//  5 N_TERMS=2, 0x00000000 then 0x40A00000 -> Out=0x40A00000 (zero operand path).
//  6 rst pulse in ADD state -> next edge Out=0, valid_out=0, ready_out=1.
//    clear_in after 1 of 2 terms, then 0x3F800000 x2 -> Out=0x40000000.
//  7 FP_ACC_OVF_EN, N_TERMS=2, 0x7F7FFFFF x2 -> Out=0x7F800000, ovf_out=1.
//    Without the macro -> Out=0x7FFFFFFF.

Source files
------------

// File: rtl/fp_acc_pkg.sv
// Shared types and field constants for the single-precision accumulator.
package fp_acc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = 24;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter over a 24-bit mantissa; all-zero input yields 24.
module fp_lzc24 (
    input  logic [23:0] din,
    output logic [4:0]  lz
);

    // Highest set bit wins because later loop iterations overwrite earlier ones.
    always_comb begin
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (din[i]) lz = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fp_accumulate.sv
// Sequential IEEE-754 single-precision accumulator: sums N_TERMS product words through an
// ALIGN/ADD/NORM pipeline-in-time, then presents the sum on Out with a one-cycle valid_out.
// Optional build macro FP_ACC_OVF_EN adds the ovf_out port and exponent saturation; without it
// the result exponent wraps to its low 8 bits.
// Handshake: a term is taken on a rising edge where valid_in && ready_out; ready_out is high only
// in IDLE and any valid_in seen while it is low is discarded.
module fp_accumulate
    import fp_acc_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] In_Data,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        clear_in,
    output logic [31:0] Out,
    output logic        valid_out
`ifdef FP_ACC_OVF_EN
    ,
    output logic        ovf_out
`endif
);

    state_t             state, state_nxt;
    logic [31:0]        acc, opnd, out_reg;
    logic [CNT_W-1:0]   count, count_nxt;

    // ALIGN stage results
    logic [MANT_W-1:0]  mant_big, mant_small;
    logic               sign_big, sign_small;
    logic [8:0]         exp_r;
    // ADD stage results
    logic [MANT_W:0]    sum_r;
    logic               sign_r;

    // Combinational stage values
    logic [EXP_W-1:0]   a_exp, b_exp, diff;
    logic [MANT_W-1:0]  a_mant, b_mant, al_big, al_small;
    logic               al_sign_big, al_sign_small;
    logic [8:0]         al_exp;
    logic [MANT_W:0]    add_sum;
    logic               add_sign;
    logic [4:0]         lz;
    logic [MANT_W-1:0]  norm_mant;
    logic [8:0]         norm_exp;
    logic [31:0]        norm_res;
`ifdef FP_ACC_OVF_EN
    logic               ovf_set, ovf_flag, ovf_reg;
`else
    logic               unused_exp_msb;
    assign unused_exp_msb = norm_exp[8];
`endif

    assign count_nxt = count + 1'b1;

    fp_lzc24 u_lzc (
        .din (sum_r[MANT_W-1:0]),
        .lz  (lz)
    );

    // Align: pick the larger-exponent operand and shift the other right (truncating).
    always_comb begin
        a_exp  = acc[30:23];
        b_exp  = opnd[30:23];
        a_mant = (a_exp == 8'd0) ? '0 : {1'b1, acc[22:0]};
        b_mant = (b_exp == 8'd0) ? '0 : {1'b1, opnd[22:0]};
        if (a_exp >= b_exp) begin
            diff          = a_exp - b_exp;
            al_big        = a_mant;
            al_small      = b_mant;
            al_sign_big   = acc[31];
            al_sign_small = opnd[31];
            al_exp        = {1'b0, a_exp};
        end else begin
            diff          = b_exp - a_exp;
            al_big        = b_mant;
            al_small      = a_mant;
            al_sign_big   = opnd[31];
            al_sign_small = acc[31];
            al_exp        = {1'b0, b_exp};
        end
        if (diff >= 8'd24) al_small = '0;
        else               al_small = al_small >> diff;
    end

    // Add: signed-magnitude add; exact cancellation gives +0.
    always_comb begin
        add_sum  = '0;
        add_sign = 1'b0;
        if (sign_big == sign_small) begin
            add_sum  = {1'b0, mant_big} + {1'b0, mant_small};
            add_sign = sign_big;
        end else if (mant_big > mant_small) begin
            add_sum  = {1'b0, mant_big - mant_small};
            add_sign = sign_big;
        end else if (mant_small > mant_big) begin
            add_sum  = {1'b0, mant_small - mant_big};
            add_sign = sign_small;
        end
    end

    // Normalize: carry shifts right, otherwise shift left by leading zeros; underflow flushes to +0.
    always_comb begin
        norm_mant = '0;
        norm_exp  = '0;
        norm_res  = '0;
`ifdef FP_ACC_OVF_EN
        ovf_set   = 1'b0;
`endif
        if (sum_r[MANT_W]) begin
            norm_mant = sum_r[MANT_W:1];
            norm_exp  = exp_r + 9'd1;
        end else begin
            norm_mant = sum_r[MANT_W-1:0] << lz;
            norm_exp  = exp_r - {4'd0, lz};
        end
        if (!sum_r[MANT_W] && ((sum_r == '0) || (exp_r <= {4'd0, lz}))) begin
            norm_res = '0;
`ifdef FP_ACC_OVF_EN
        end else if (norm_exp >= 9'(EXP_MAX)) begin
            norm_res = {sign_r, 8'hFF, 23'h0};
            ovf_set  = 1'b1;
`endif
        end else begin
            norm_res = {sign_r, norm_exp[7:0], norm_mant[22:0]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: clear_in forces IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (clear_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (valid_in) state_nxt = ALIGN;
                ALIGN:   state_nxt = ADD;
                ADD:     state_nxt = NORM;
                NORM:    state_nxt = (count_nxt == CNT_W'(N_TERMS)) ? DONE : IDLE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: the result is visible together with its valid pulse, then held from out_reg.
    always_comb begin
        ready_out = (state == IDLE);
        valid_out = (state == DONE) && !clear_in;
        Out       = valid_out ? acc : out_reg;
`ifdef FP_ACC_OVF_EN
        ovf_out   = valid_out ? ovf_flag : ovf_reg;
`endif
    end

    // Datapath registers, advanced one stage per FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            opnd       <= '0;
            out_reg    <= '0;
            count      <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            exp_r      <= '0;
            sum_r      <= '0;
            sign_r     <= 1'b0;
`ifdef FP_ACC_OVF_EN
            ovf_flag   <= 1'b0;
            ovf_reg    <= 1'b0;
`endif
        end else if (clear_in) begin
            acc        <= '0;
            count      <= '0;
`ifdef FP_ACC_OVF_EN
            ovf_flag   <= 1'b0;
            ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (valid_in) opnd <= In_Data;
                ALIGN: begin
                    mant_big   <= al_big;
                    mant_small <= al_small;
                    sign_big   <= al_sign_big;
                    sign_small <= al_sign_small;
                    exp_r      <= al_exp;
                end
                ADD: begin
                    sum_r  <= add_sum;
                    sign_r <= add_sign;
                end
                NORM: begin
                    acc   <= norm_res;
                    count <= count_nxt;
`ifdef FP_ACC_OVF_EN
                    ovf_flag <= ovf_flag | ovf_set;
`endif
                end
                DONE: begin
                    out_reg <= acc;
                    acc     <= '0;
                    count   <= '0;
`ifdef FP_ACC_OVF_EN
                    ovf_reg  <= ovf_flag;
                    ovf_flag <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
